// File: rtl/rc4_pkg.sv
// rc4_pkg
// Shared types and constants for the RC4 S-memory datapath.
//   ksa_state_t   : key-scheduling controller states
//   S_DEPTH       : number of S-RAM entries
//   S_ADDR_W      : S-RAM address width
//   S_DATA_W      : S-RAM data width
//   KEY_MAX_BYTES : largest supported secret key length (bound check)
package rc4_pkg;

  localparam int S_DEPTH       = 256;
  localparam int S_ADDR_W      = 8;
  localparam int S_DATA_W      = 8;
  localparam int KEY_MAX_BYTES = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ_I,
    S_LATCH_I,
    S_READ_J,
    S_LATCH_J,
    S_WRITE_I,
    S_WRITE_J,
    S_DONE
  } ksa_state_t;

endpackage

// File: rtl/ksa_controller_if.sv
// ksa_controller_if
// S-RAM port bundle between the KSA controller and the S memory.
//   address : S-RAM address            (master -> slave)
//   data    : S-RAM write data         (master -> slave)
//   wren    : S-RAM write enable       (master -> slave)
//   q       : S-RAM read data, valid the cycle after address (slave -> master)
interface ksa_controller_if;

  logic [rc4_pkg::S_ADDR_W-1:0] address;
  logic [rc4_pkg::S_DATA_W-1:0] data;
  logic                         wren;
  logic [rc4_pkg::S_DATA_W-1:0] q;

  modport master (output address, output data, output wren, input q);
  modport slave  (input address, input data, input wren, output q);

endinterface

// File: rtl/ksa_key_select.sv
// ksa_key_select
// Holds the latched secret key, the wrapping key-byte index and the byte mux.
//   clock      : system clock
//   rst        : synchronous active-high reset
//   load       : capture secret_key into the key register
//   advance    : step the key index, wrapping after the last byte
//   clear      : return the key index to byte 0
//   secret_key : key, byte 0 in the most significant byte
//   key_byte   : currently selected key byte
module ksa_key_select
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = 3
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   advance,
  input  logic                   clear,
  input  logic [KEY_BYTES*8-1:0] secret_key,
  output logic [7:0]             key_byte
);

  localparam int KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KIDX_W-1:0] KIDX_LAST = KIDX_W'(KEY_BYTES - 1);

  generate
    if (KEY_BYTES < 1 || KEY_BYTES > KEY_MAX_BYTES) begin : g_bad_key_len
      $error("ksa_key_select: KEY_BYTES out of range");
    end
  endgenerate

  logic [7:0]        key_q [KEY_BYTES];
  logic [KIDX_W-1:0] kidx_q;

  // Wrapping index: compare against the last byte instead of a modulo.
  always_ff @(posedge clock) begin
    if (rst || clear) begin
      kidx_q <= '0;
    end else if (advance) begin
      kidx_q <= (kidx_q == KIDX_LAST) ? '0 : kidx_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      for (int k = 0; k < KEY_BYTES; k++) key_q[k] <= '0;
    end else if (load) begin
      for (int k = 0; k < KEY_BYTES; k++) key_q[k] <= secret_key[KEY_BYTES*8-1-8*k -: 8];
    end
  end

  assign key_byte = key_q[kidx_q];

endmodule

// File: rtl/ksa_controller.sv
// ksa_controller
// RC4 key-scheduling pass over a 256x8 S-RAM already holding s[i]=i.
// For i = 0..255: j += s[i] + key[i mod KEY_BYTES]; swap s[i], s[j].
//   clock      : system clock
//   rst        : synchronous active-high reset
//   start      : begins a pass when idle or done
//   secret_key : key, byte 0 in the most significant byte
//   sram       : S-RAM port (master side)
//   busy       : pass in progress
//   done       : pass complete, held until a new start or rst
// Optional build macro KSA_SAME_ADDR_SKIP_EN: when the new j equals i the
// swap is a no-op, so the iteration ends in LATCH_I (2 cycles, no writes).
//
// state     | meaning
// ----------+-------------------------------------------
// S_IDLE    | waiting for start
// S_READ_I  | present address i
// S_LATCH_I | capture s[i], update j
// S_READ_J  | present address j
// S_LATCH_J | capture s[j]
// S_WRITE_I | s[i] <= old s[j]
// S_WRITE_J | s[j] <= old s[i], advance i or finish
// S_DONE    | pass complete, waiting for start
module ksa_controller
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = 3
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic                   start,
  input  logic [KEY_BYTES*8-1:0] secret_key,
  ksa_controller_if.master       sram,
  output logic                   busy,
  output logic                   done
);

  localparam logic [S_ADDR_W-1:0] I_LAST = S_ADDR_W'(S_DEPTH - 1);

  ksa_state_t            state_q, state_d;
  logic [S_ADDR_W-1:0]   i_q, j_q;
  logic [S_DATA_W-1:0]   si_q, sj_q;
  logic [S_ADDR_W-1:0]   j_new;
  logic [7:0]            key_byte;
  logic                  accept, advance;

  ksa_key_select #(.KEY_BYTES(KEY_BYTES)) u_key_select (
    .clock      (clock),
    .rst        (rst),
    .load       (accept),
    .advance    (advance),
    .clear      (accept),
    .secret_key (secret_key),
    .key_byte   (key_byte)
  );

  always_ff @(posedge clock) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    advance = 1'b0;
    j_new   = j_q + sram.q + key_byte;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = S_READ_I;
        end
      end
      S_READ_I:  state_d = S_LATCH_I;
      S_LATCH_I: begin
`ifdef KSA_SAME_ADDR_SKIP_EN
        if (j_new == i_q) begin
          if (i_q == I_LAST) begin
            state_d = S_DONE;
          end else begin
            advance = 1'b1;
            state_d = S_READ_I;
          end
        end else begin
          state_d = S_READ_J;
        end
`else
        state_d = S_READ_J;
`endif
      end
      S_READ_J:  state_d = S_LATCH_J;
      S_LATCH_J: state_d = S_WRITE_I;
      S_WRITE_I: state_d = S_WRITE_J;
      S_WRITE_J: begin
        if (i_q == I_LAST) begin
          state_d = S_DONE;
        end else begin
          advance = 1'b1;
          state_d = S_READ_I;
        end
      end
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      i_q  <= '0;
      j_q  <= '0;
      si_q <= '0;
      sj_q <= '0;
    end else begin
      if (accept) begin
        i_q <= '0;
        j_q <= '0;
      end
      if (state_q == S_LATCH_I) begin
        si_q <= sram.q;
        j_q  <= j_new;
      end
      if (state_q == S_LATCH_J) sj_q <= sram.q;
      if (advance) i_q <= i_q + 1'b1;
    end
  end

  // Outputs depend only on registered state and indices.
  always_comb begin
    sram.address = '0;
    sram.data    = '0;
    sram.wren    = 1'b0;
    case (state_q)
      S_READ_I:  sram.address = i_q;
      S_READ_J:  sram.address = j_q;
      S_WRITE_I: begin
        sram.address = i_q;
        sram.data    = sj_q;
        sram.wren    = 1'b1;
      end
      S_WRITE_J: begin
        sram.address = j_q;
        sram.data    = si_q;
        sram.wren    = 1'b1;
      end
      default: ;
    endcase
    busy = (state_q != S_IDLE) && (state_q != S_DONE);
    done = (state_q == S_DONE);
  end

endmodule
